flash_boot_loader: RTL and testbench
====================================

# flash_boot_loader

Boot-time copy engine that reads a kernel image from the 16-bit parallel NOR flash and writes it as 32-bit words into base SRAM. The RAM wrapper consumes its write requests and `load_complete`. The CPU is held off until `load_complete` rises. The block replaces ad-hoc flash sequencing with a single state machine, an explicit wait-state counter and a write handshake toward SRAM.

## Interface

Parameters:
- `WORD_COUNT`, default 4210: number of 32-bit words to copy (0..2^20-1).
- `FLASH_WAIT`, default 8: `clk` cycles each flash read is held before sampling (1..255).
- `FLASH_BASE`, default 0: first flash halfword address (22 bits).
- `SRAM_BASE`, default 0: first SRAM word address (20 bits).

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flash_addr` output 22: halfword address, flash A[22:1].
- `flash_data` input 16: flash read data. The bus is read-only here; the top level ties the tri-state to input.
- `flash_ce_n` output 1: flash chip enable, active low.
- `flash_oe_n` output 1: flash output enable, active low.
- `flash_we_n` output 1: constant 1.
- `flash_rp_n` output 1: 0 during `rst`, 1 otherwise.
- `flash_byte_n` output 1: constant 1 (16-bit mode).
- `flash_vpen` output 1: constant 0.
- `wr_valid` output 1: SRAM write request.
- `wr_ready` input 1: SRAM write accepted this cycle.
- `wr_addr` output 20: SRAM word address.
- `wr_data` output 32: SRAM write data.
- `load_complete` output 1: copy finished. Stays high until `rst`.
- `words_loaded` output 20: count of words accepted by SRAM.
- `checksum` output 32: running sum of written words (see Configuration).

## Operation

- States: READ_LO, READ_HI, WRITE, DONE. `rst` forces READ_LO, or DONE if `WORD_COUNT`==0.
- `idx` is the 20-bit word index, reset to 0.
- READ_LO:
  - `flash_addr` = `FLASH_BASE` + 2·`idx`.
  - `ce_n`/`oe_n` are low for `FLASH_WAIT` cycles. `flash_data` is captured into `lo` on the edge ending the last of those cycles.
  - One recovery cycle follows with `oe_n` high and `ce_n` low. Then go to READ_HI.
- READ_HI: identical to READ_LO, with address +1, capturing into `hi`. Then go to WRITE.
- WRITE:
  - `wr_valid`=1, `wr_data`={`hi`,`lo`}, `wr_addr`=`SRAM_BASE`+`idx`. `ce_n`/`oe_n` are high.
  - Outputs are held stable while `wr_ready`=0.
  - On `wr_ready`=1: `words_loaded`++ and `idx`++. If `idx`+1==`WORD_COUNT`, go to DONE; otherwise go to READ_LO.
- DONE: `load_complete`=1. Flash is deselected (`ce_n`=`oe_n`=1). `wr_valid`=0. The state persists until `rst`.
- Address arithmetic is modulo 2^22 (flash) and 2^20 (SRAM). Wrap is silent.
- `rst` mid-copy: abandon the operation immediately. All registers return to reset values and the copy restarts from `idx`=0 after `rst` falls.

## Timing

- Reset values:
  - `flash_ce_n`=1, `flash_oe_n`=1, `flash_addr`=0.
  - `wr_valid`=0, `wr_addr`=0, `wr_data`=0.
  - `load_complete`=0, `words_loaded`=0, `checksum`=0.
- Counting from the first cycle after `rst` falls as cycle 0:
  - `ce_n`/`oe_n` go low in cycle 0.
  - The first `wr_valid` is high in cycle 2·(`FLASH_WAIT`+1).
- Word period is 2·`FLASH_WAIT`+3 cycles when `wr_ready` is high. Each cycle `wr_ready` is low adds one cycle.
- `load_complete` rises the cycle after the final accepted write. `words_loaded` and `checksum` update in the same cycle as that acceptance.
- `flash_addr` changes only in recovery or WRITE cycles, never while `oe_n` is low.

## Configuration

- `BOOT_CHECKSUM_EN` defined:
  - `checksum` accumulates `wr_data` (mod 2^32) on each accepted write.
  - The sum is cleared by `rst` and frozen in DONE.
- Not defined: `checksum` is constant 0 and the adder is removed.

## Test plan

- Baseline run:
  - Stimulus: `WORD_COUNT`=3, `FLASH_WAIT`=2, flash model returns data = halfword address, `wr_ready`=1.
  - Writes: (0, 0x00010000) in cycle 6, (1, 0x00030002) in cycle 13, (2, 0x00050004) in cycle 20.
  - `load_complete`=1 from cycle 21; `words_loaded`=3.
  - With `BOOT_CHECKSUM_EN`: `checksum`=0x00090006.
- Backpressure:
  - Stimulus: same setup, with `wr_ready` held low for 4 cycles at the first write.
  - `wr_valid`/`wr_addr`/`wr_data` stay stable for 5 cycles.
  - `load_complete` is delayed to cycle 25.
  - No flash access occurs during the stall.
- Empty image: `WORD_COUNT`=0 → `load_complete`=1 in cycle 0, no `wr_valid`, `flash_ce_n` stays 1.
- Reset mid-copy:
  - Stimulus: `rst` asserted in cycle 9 for 1 cycle, baseline config.
  - All outputs return to reset values.
  - The next write is (0, 0x00010000) 6 cycles after `rst` falls.
  - `words_loaded` restarts at 0.
- Bus timing: check every cycle that `flash_addr` is stable while `flash_oe_n`=0, and that `flash_we_n`=1 throughout. Check `flash_rp_n`=0 only during `rst`.
- Base offsets: `FLASH_BASE`=0x100, `SRAM_BASE`=0xFFFFF, `WORD_COUNT`=2 → the first write goes to `wr_addr` 0xFFFFF and the second wraps to 0x00000. Flash addresses run 0x100 through 0x103.

Source files
------------

// File: rtl/flash_boot_loader_if.sv
// SRAM write channel between the boot loader (master) and the RAM wrapper (slave).
interface flash_boot_loader_if;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 32;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/flash_boot_loader.sv
// Boot copy engine: reads WORD_COUNT words as halfword pairs from NOR flash and writes them to SRAM.
// Define BOOT_CHECKSUM_EN to accumulate a running sum of written words on checksum.
module flash_boot_loader #(
    parameter int unsigned WORD_COUNT = 4210,
    parameter int unsigned FLASH_WAIT = 8,
    parameter int unsigned FLASH_BASE = 0,
    parameter int unsigned SRAM_BASE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [21:0]          flash_addr,
    input  logic [15:0]          flash_data,
    output logic                 flash_ce_n,
    output logic                 flash_oe_n,
    output logic                 flash_we_n,
    output logic                 flash_rp_n,
    output logic                 flash_byte_n,
    output logic                 flash_vpen,
    flash_boot_loader_if.master  wr,
    output logic                 load_complete,
    output logic [19:0]          words_loaded,
    output logic [31:0]          checksum
);
    localparam int unsigned FA_W = 22;
    localparam int unsigned SA_W = 20;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] WAIT_CNT     = CNT_W'(FLASH_WAIT);
    localparam logic [SA_W-1:0]  WORD_TOTAL   = SA_W'(WORD_COUNT);
    localparam logic [FA_W-1:0]  FLASH_BASE_A = FA_W'(FLASH_BASE);
    localparam logic [SA_W-1:0]  SRAM_BASE_A  = SA_W'(SRAM_BASE);
    localparam bit               EMPTY_IMAGE  = (WORD_COUNT == 0);

    typedef enum logic [1:0] {
        READ_LO,
        READ_HI,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    logic [SA_W-1:0]  idx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      lo;
    logic [15:0]      hi;

    logic [SA_W-1:0]  idx_next_c;
    logic [FA_W-1:0]  lo_addr_c;
    logic [FA_W-1:0]  hi_addr_c;
    logic [FA_W-1:0]  next_addr_c;
    logic             last_c;
    logic             accept_c;

    assign flash_we_n   = 1'b1;
    assign flash_byte_n = 1'b1;
    assign flash_vpen   = 1'b0;

    // Halfword addresses of the current word and the one after it; all wrap silently.
    assign idx_next_c  = idx + SA_W'(1);
    assign lo_addr_c   = FLASH_BASE_A + {1'b0, idx, 1'b0};
    assign hi_addr_c   = lo_addr_c + FA_W'(1);
    assign next_addr_c = FLASH_BASE_A + {1'b0, idx_next_c, 1'b0};
    assign last_c      = (idx_next_c == WORD_TOTAL);
    assign accept_c    = (state == WRITE) && wr.wr_valid && wr.wr_ready;

    // state/cnt describe the cycle being launched at each edge, so every bus output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY_IMAGE ? DONE : READ_LO;
            idx           <= '0;
            cnt           <= '0;
            lo            <= '0;
            hi            <= '0;
            flash_addr    <= '0;
            flash_ce_n    <= 1'b1;
            flash_oe_n    <= 1'b1;
            flash_rp_n    <= 1'b0;
            wr.wr_valid   <= 1'b0;
            wr.wr_addr    <= '0;
            wr.wr_data    <= '0;
            load_complete <= 1'b0;
            words_loaded  <= '0;
        end else begin
            flash_rp_n <= 1'b1;
            case (state)
                READ_LO, READ_HI: begin
                    flash_ce_n <= 1'b0;
                    if (cnt < WAIT_CNT) begin
                        flash_oe_n <= 1'b0;
                        flash_addr <= (state == READ_LO) ? lo_addr_c : hi_addr_c;
                        cnt        <= cnt + CNT_W'(1);
                    end else begin
                        // Sample edge; the following cycle is the oe-high recovery cycle.
                        flash_oe_n <= 1'b1;
                        cnt        <= '0;
                        if (state == READ_LO) begin
                            lo         <= flash_data;
                            flash_addr <= hi_addr_c;
                            state      <= READ_HI;
                        end else begin
                            hi    <= flash_data;
                            state <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    flash_ce_n <= 1'b1;
                    flash_oe_n <= 1'b1;
                    if (!wr.wr_valid) begin
                        wr.wr_valid <= 1'b1;
                        wr.wr_addr  <= SRAM_BASE_A + idx;
                        wr.wr_data  <= {hi, lo};
                        flash_addr  <= next_addr_c;
                    end else if (wr.wr_ready) begin
                        wr.wr_valid  <= 1'b0;
                        idx          <= idx_next_c;
                        words_loaded <= words_loaded + SA_W'(1);
                        if (last_c) begin
                            state         <= DONE;
                            load_complete <= 1'b1;
                        end else begin
                            // Launch the first wait cycle of the next word directly from the accept.
                            state      <= READ_LO;
                            cnt        <= CNT_W'(1);
                            flash_ce_n <= 1'b0;
                            flash_oe_n <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    flash_ce_n    <= 1'b1;
                    flash_oe_n    <= 1'b1;
                    wr.wr_valid   <= 1'b0;
                    load_complete <= 1'b1;
                end
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Sum of accepted words; no accepts occur in DONE, so the value freezes there.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept_c) begin
            checksum <= checksum + wr.wr_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader: three instances cover the baseline, empty-image and base-offset builds.
module tb_flash_boot_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef BOOT_CHECKSUM_EN
    localparam logic [31:0] EXP_SUM_A = 32'h0009_0006;
`else
    localparam logic [31:0] EXP_SUM_A = 32'h0000_0000;
`endif

    // Instance a: WORD_COUNT=3, FLASH_WAIT=2, zero bases
    logic        rst_a;
    logic [21:0] fa_a;
    logic [15:0] fd_a;
    logic        ce_a, oe_a, we_a, rp_a, byte_a, vpen_a, lc_a;
    logic [19:0] wl_a;
    logic [31:0] cs_a;
    flash_boot_loader_if wr_a ();
    assign fd_a = fa_a[15:0];

    flash_boot_loader #(.WORD_COUNT(3), .FLASH_WAIT(2), .FLASH_BASE(0), .SRAM_BASE(0)) dut_a (
        .clk(clk), .rst(rst_a), .flash_addr(fa_a), .flash_data(fd_a),
        .flash_ce_n(ce_a), .flash_oe_n(oe_a), .flash_we_n(we_a), .flash_rp_n(rp_a),
        .flash_byte_n(byte_a), .flash_vpen(vpen_a), .wr(wr_a),
        .load_complete(lc_a), .words_loaded(wl_a), .checksum(cs_a)
    );

    // Instance b: empty image
    logic        rst_b;
    logic [21:0] fa_b;
    logic [15:0] fd_b;
    logic        ce_b, oe_b, we_b, rp_b, byte_b, vpen_b, lc_b;
    logic [19:0] wl_b;
    logic [31:0] cs_b;
    flash_boot_loader_if wr_b ();
    assign fd_b = fa_b[15:0];

    flash_boot_loader #(.WORD_COUNT(0), .FLASH_WAIT(2), .FLASH_BASE(0), .SRAM_BASE(0)) dut_b (
        .clk(clk), .rst(rst_b), .flash_addr(fa_b), .flash_data(fd_b),
        .flash_ce_n(ce_b), .flash_oe_n(oe_b), .flash_we_n(we_b), .flash_rp_n(rp_b),
        .flash_byte_n(byte_b), .flash_vpen(vpen_b), .wr(wr_b),
        .load_complete(lc_b), .words_loaded(wl_b), .checksum(cs_b)
    );

    // Instance c: offset bases with SRAM address wrap
    logic        rst_c;
    logic [21:0] fa_c;
    logic [15:0] fd_c;
    logic        ce_c, oe_c, we_c, rp_c, byte_c, vpen_c, lc_c;
    logic [19:0] wl_c;
    logic [31:0] cs_c;
    flash_boot_loader_if wr_c ();
    assign fd_c = fa_c[15:0];

    flash_boot_loader #(.WORD_COUNT(2), .FLASH_WAIT(2), .FLASH_BASE('h100), .SRAM_BASE('hFFFFF)) dut_c (
        .clk(clk), .rst(rst_c), .flash_addr(fa_c), .flash_data(fd_c),
        .flash_ce_n(ce_c), .flash_oe_n(oe_c), .flash_we_n(we_c), .flash_rp_n(rp_c),
        .flash_byte_n(byte_c), .flash_vpen(vpen_c), .wr(wr_c),
        .load_complete(lc_c), .words_loaded(wl_c), .checksum(cs_c)
    );

    // Each start task returns at the negedge of cycle -1 (reset values visible, rst just released).
    task automatic start_a();
        @(negedge clk); rst_a = 1'b1; wr_a.wr_ready = 1'b1;
        @(negedge clk); rst_a = 1'b0;
    endtask

    task automatic start_b();
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
    endtask

    task automatic start_c();
        @(negedge clk); rst_c = 1'b1;
        @(negedge clk); rst_c = 1'b0;
    endtask

    task automatic test_reset();
        start_a();
        checks++; if (ce_a !== 1'b1) begin errors++; $display("FAIL reset_ce_n got %b want 1", ce_a); end
        checks++; if (oe_a !== 1'b1) begin errors++; $display("FAIL reset_oe_n got %b want 1", oe_a); end
        checks++; if (fa_a !== 22'h0) begin errors++; $display("FAIL reset_flash_addr got %h want 0", fa_a); end
        checks++; if (rp_a !== 1'b0) begin errors++; $display("FAIL reset_rp_n got %b want 0", rp_a); end
        checks++; if (wr_a.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_a.wr_valid); end
        checks++; if (wr_a.wr_addr !== 20'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_a.wr_addr); end
        checks++; if (wr_a.wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_a.wr_data); end
        checks++; if (lc_a !== 1'b0) begin errors++; $display("FAIL reset_load_complete got %b want 0", lc_a); end
        checks++; if (wl_a !== 20'h0) begin errors++; $display("FAIL reset_words_loaded got %h want 0", wl_a); end
        checks++; if (cs_a !== 32'h0) begin errors++; $display("FAIL reset_checksum got %h want 0", cs_a); end
    endtask

    task automatic test_baseline();
        logic        exp_v;
        logic        exp_lc;
        logic [19:0] exp_addr;
        logic [31:0] exp_data;
        int          k;
        start_a();
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (ce_a !== 1'b0 || oe_a !== 1'b0) begin
                    errors++; $display("FAIL baseline_first_read ce_n/oe_n got %b%b want 00", ce_a, oe_a);
                end
            end
            exp_v = (c == 6) || (c == 13) || (c == 20);
            checks++; if (wr_a.wr_valid !== exp_v) begin
                errors++; $display("FAIL baseline_wr_valid cycle %0d got %b want %b", c, wr_a.wr_valid, exp_v);
            end
            if (exp_v) begin
                k        = (c - 6) / 7;
                exp_addr = 20'(k);
                exp_data = {16'(2 * k + 1), 16'(2 * k)};
                checks++; if (wr_a.wr_addr !== exp_addr) begin
                    errors++; $display("FAIL baseline_wr_addr cycle %0d got %h want %h", c, wr_a.wr_addr, exp_addr);
                end
                checks++; if (wr_a.wr_data !== exp_data) begin
                    errors++; $display("FAIL baseline_wr_data cycle %0d got %h want %h", c, wr_a.wr_data, exp_data);
                end
            end
            exp_lc = (c >= 21);
            checks++; if (lc_a !== exp_lc) begin
                errors++; $display("FAIL baseline_load_complete cycle %0d got %b want %b", c, lc_a, exp_lc);
            end
        end
        checks++; if (wl_a !== 20'd3) begin errors++; $display("FAIL baseline_words_loaded got %0d want 3", wl_a); end
        checks++; if (cs_a !== EXP_SUM_A) begin errors++; $display("FAIL baseline_checksum got %h want %h", cs_a, EXP_SUM_A); end
    endtask

    task automatic test_backpressure();
        logic exp_v;
        logic exp_lc;
        logic stall;
        start_a();
        for (int c = 0; c <= 27; c++) begin
            @(negedge clk);
            stall = (c >= 6) && (c <= 10);
            exp_v = stall || (c == 17) || (c == 24);
            checks++; if (wr_a.wr_valid !== exp_v) begin
                errors++; $display("FAIL bp_wr_valid cycle %0d got %b want %b", c, wr_a.wr_valid, exp_v);
            end
            if (stall) begin
                checks++; if (wr_a.wr_addr !== 20'h0 || wr_a.wr_data !== 32'h0001_0000) begin
                    errors++; $display("FAIL bp_hold cycle %0d got %h/%h want 00000/00010000", c, wr_a.wr_addr, wr_a.wr_data);
                end
                checks++; if (ce_a !== 1'b1 || oe_a !== 1'b1) begin
                    errors++; $display("FAIL bp_flash_idle cycle %0d got ce_n/oe_n %b%b want 11", c, ce_a, oe_a);
                end
            end
            if (c == 24) begin
                checks++; if (wr_a.wr_data !== 32'h0005_0004) begin
                    errors++; $display("FAIL bp_last_data got %h want 00050004", wr_a.wr_data);
                end
            end
            exp_lc = (c >= 25);
            checks++; if (lc_a !== exp_lc) begin
                errors++; $display("FAIL bp_load_complete cycle %0d got %b want %b", c, lc_a, exp_lc);
            end
            wr_a.wr_ready = !((c >= 6) && (c <= 9));
        end
        checks++; if (wl_a !== 20'd3) begin errors++; $display("FAIL bp_words_loaded got %0d want 3", wl_a); end
    endtask

    task automatic test_reset_mid_copy();
        logic        exp_v;
        logic [19:0] exp_wl;
        start_a();
        for (int c = 0; c <= 9; c++) @(negedge clk);
        checks++; if (wl_a !== 20'd1) begin errors++; $display("FAIL mid_pre_words_loaded got %0d want 1", wl_a); end
        rst_a = 1'b1;
        @(negedge clk);
        checks++; if (ce_a !== 1'b1 || oe_a !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ce_oe got %b%b want 11", ce_a, oe_a);
        end
        checks++; if (fa_a !== 22'h0) begin errors++; $display("FAIL mid_reset_flash_addr got %h want 0", fa_a); end
        checks++; if (rp_a !== 1'b0) begin errors++; $display("FAIL mid_reset_rp_n got %b want 0", rp_a); end
        checks++; if (wr_a.wr_valid !== 1'b0 || wr_a.wr_addr !== 20'h0 || wr_a.wr_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset_wr got %b/%h/%h want 0/0/0", wr_a.wr_valid, wr_a.wr_addr, wr_a.wr_data);
        end
        checks++; if (lc_a !== 1'b0 || wl_a !== 20'h0 || cs_a !== 32'h0) begin
            errors++; $display("FAIL mid_reset_status got %b/%h/%h want 0/0/0", lc_a, wl_a, cs_a);
        end
        rst_a = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            exp_v = (c == 6);
            checks++; if (wr_a.wr_valid !== exp_v) begin
                errors++; $display("FAIL mid_restart_wr_valid cycle %0d got %b want %b", c, wr_a.wr_valid, exp_v);
            end
            if (exp_v) begin
                checks++; if (wr_a.wr_addr !== 20'h0 || wr_a.wr_data !== 32'h0001_0000) begin
                    errors++; $display("FAIL mid_restart_write got %h/%h want 00000/00010000", wr_a.wr_addr, wr_a.wr_data);
                end
            end
            exp_wl = (c == 7) ? 20'd1 : 20'd0;
            checks++; if (wl_a !== exp_wl) begin
                errors++; $display("FAIL mid_restart_words_loaded cycle %0d got %0d want %0d", c, wl_a, exp_wl);
            end
        end
    endtask

    task automatic test_bus_timing();
        logic        prev_oe;
        logic [21:0] prev_addr;
        start_a();
        prev_oe   = 1'b1;
        prev_addr = 22'h0;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            checks++; if (we_a !== 1'b1 || byte_a !== 1'b1 || vpen_a !== 1'b0) begin
                errors++; $display("FAIL bus_constants cycle %0d got we_n/byte_n/vpen %b%b%b want 110", c, we_a, byte_a, vpen_a);
            end
            checks++; if (rp_a !== 1'b1) begin
                errors++; $display("FAIL bus_rp_n cycle %0d got %b want 1", c, rp_a);
            end
            if (oe_a === 1'b0) begin
                checks++; if (ce_a !== 1'b0) begin
                    errors++; $display("FAIL bus_oe_without_ce cycle %0d got ce_n %b want 0", c, ce_a);
                end
                if (prev_oe === 1'b0) begin
                    checks++; if (fa_a !== prev_addr) begin
                        errors++; $display("FAIL bus_addr_stable cycle %0d got %h want %h", c, fa_a, prev_addr);
                    end
                end
            end
            prev_oe   = oe_a;
            prev_addr = fa_a;
        end
    endtask

    task automatic test_empty_image();
        start_b();
        checks++; if (lc_b !== 1'b0 || rp_b !== 1'b0) begin
            errors++; $display("FAIL empty_reset got lc/rp_n %b%b want 00", lc_b, rp_b);
        end
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (lc_b !== 1'b1) begin
                errors++; $display("FAIL empty_load_complete cycle %0d got %b want 1", c, lc_b);
            end
            checks++; if (wr_b.wr_valid !== 1'b0 || ce_b !== 1'b1) begin
                errors++; $display("FAIL empty_idle cycle %0d got wr_valid/ce_n %b%b want 01", c, wr_b.wr_valid, ce_b);
            end
        end
        checks++; if (wl_b !== 20'h0) begin errors++; $display("FAIL empty_words_loaded got %0d want 0", wl_b); end
    endtask

    task automatic test_base_offsets();
        int          ph;
        int          wd;
        logic        exp_oe_low;
        logic        exp_v;
        logic        exp_lc;
        logic [21:0] exp_fa;
        logic [19:0] exp_wa;
        logic [31:0] exp_wd;
        wr_c.wr_ready = 1'b1;
        start_c();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            ph = c % 7;
            wd = c / 7;
            exp_oe_low = (c < 14) && (ph == 0 || ph == 1 || ph == 3 || ph == 4);
            checks++; if (oe_c !== !exp_oe_low) begin
                errors++; $display("FAIL base_oe_n cycle %0d got %b want %b", c, oe_c, !exp_oe_low);
            end
            if (exp_oe_low) begin
                exp_fa = 22'(32'h100 + 2 * wd + ((ph >= 3) ? 1 : 0));
                checks++; if (fa_c !== exp_fa) begin
                    errors++; $display("FAIL base_flash_addr cycle %0d got %h want %h", c, fa_c, exp_fa);
                end
            end
            exp_v = (c == 6) || (c == 13);
            checks++; if (wr_c.wr_valid !== exp_v) begin
                errors++; $display("FAIL base_wr_valid cycle %0d got %b want %b", c, wr_c.wr_valid, exp_v);
            end
            if (exp_v) begin
                exp_wa = 20'(32'hFFFFF + wd);
                exp_wd = {16'(32'h100 + 2 * wd + 1), 16'(32'h100 + 2 * wd)};
                checks++; if (wr_c.wr_addr !== exp_wa || wr_c.wr_data !== exp_wd) begin
                    errors++; $display("FAIL base_write cycle %0d got %h/%h want %h/%h", c, wr_c.wr_addr, wr_c.wr_data, exp_wa, exp_wd);
                end
            end
            exp_lc = (c >= 14);
            checks++; if (lc_c !== exp_lc) begin
                errors++; $display("FAIL base_load_complete cycle %0d got %b want %b", c, lc_c, exp_lc);
            end
        end
        checks++; if (wl_c !== 20'd2) begin errors++; $display("FAIL base_words_loaded got %0d want 2", wl_c); end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        wr_a.wr_ready = 1'b1;
        wr_b.wr_ready = 1'b1;
        wr_c.wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_baseline();
        test_backpressure();
        test_reset_mid_copy();
        test_bus_timing();
        test_empty_image();
        test_base_offsets();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
